pc_redirect_unit: RTL



---
 rtl/pc_redirect_unit_if.sv | 33 +++
 rtl/pc_redirect_unit.sv | 104 ++++++++++
 2 files changed

// File: rtl/pc_redirect_unit_if.sv
// Fetch-PC bundle between the redirect unit and its neighbours; misalign/bad_addr exist only with MISALIGN_TRAP_EN.
// Latency: none (wires only).
// Backpressure: stall/imem_ready travel toward the unit, the fetch request travels away.
interface pc_redirect_unit_if;
    logic        stall;
    logic        imem_ready;
    logic        branch_signal;
    logic [31:0] branch_target;
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;
    logic        redirect_busy;
`ifdef MISALIGN_TRAP_EN
    logic        misalign;
    logic [31:0] bad_addr;
`endif

    modport master (
        output stall, imem_ready, branch_signal, branch_target,
        input  pc, pc_valid, flush, redirect_busy
`ifdef MISALIGN_TRAP_EN
        , input misalign, bad_addr
`endif
    );

    modport slave (
        input  stall, imem_ready, branch_signal, branch_target,
        output pc, pc_valid, flush, redirect_busy
`ifdef MISALIGN_TRAP_EN
        , output misalign, bad_addr
`endif
    );
endinterface

// File: rtl/pc_redirect_unit.sv
// Fetch PC generator with branch redirect and a FLUSH_CYCLES-long registered flush (MISALIGN_TRAP_EN adds a trap).
// Latency: branch sampled at edge N shows pc=target and flush=1 after edge N; all outputs registered.
// Backpressure: stall or !imem_ready holds pc; a branch overrides both, and stall never extends flush.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    pc_redirect_unit_if.slave bus
);
    typedef enum logic [1:0] {
        HOLD,
        RUN,
        REDIRECT
`ifdef MISALIGN_TRAP_EN
        , HALT
`endif
    } state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic        pc_valid_q;
    logic        flush_q;
    logic        busy_q;
    logic [2:0]  cnt_q;
    logic [31:0] pc_adv;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_q;
    logic [31:0] bad_addr_q;
`endif

    assign pc_adv = (bus.stall || !bus.imem_ready) ? pc_q : pc_q + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HOLD;
            pc_q       <= RESET_PC;
            pc_valid_q <= 1'b0;
            flush_q    <= 1'b0;
            busy_q     <= 1'b0;
            cnt_q      <= 3'd0;
`ifdef MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
            bad_addr_q <= 32'd0;
`endif
        end else begin
            case (state)
                HOLD: begin
                    state      <= RUN;
                    pc_valid_q <= 1'b1;
                end
                RUN: begin
                    if (bus.branch_signal) begin
`ifdef MISALIGN_TRAP_EN
                        if (bus.branch_target[1]) begin
                            state      <= HALT;
                            misalign_q <= 1'b1;
                            bad_addr_q <= bus.branch_target;
                            pc_valid_q <= 1'b0;
                            flush_q    <= 1'b1;
                        end else
`endif
                        begin
                            state   <= REDIRECT;
                            pc_q    <= {bus.branch_target[31:2], 2'b00};
                            flush_q <= 1'b1;
                            busy_q  <= 1'b1;
                            cnt_q   <= 3'(FLUSH_CYCLES - 1);
                        end
                    end else begin
                        pc_q <= pc_adv;
                    end
                end
                REDIRECT: begin
                    // branch_signal is ignored here: execute forces it low while flush is high
                    pc_q <= pc_adv;
                    if (cnt_q == 3'd0) begin
                        state   <= RUN;
                        flush_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
`ifdef MISALIGN_TRAP_EN
                HALT: begin
                    state <= HALT;
                end
`endif
                default: state <= HOLD;
            endcase
        end
    end

    assign bus.pc            = pc_q;
    assign bus.pc_valid      = pc_valid_q;
    assign bus.flush         = flush_q;
    assign bus.redirect_busy = busy_q;
`ifdef MISALIGN_TRAP_EN
    assign bus.misalign      = misalign_q;
    assign bus.bad_addr      = bad_addr_q;
`endif
endmodule
